video_stream_writer: RTL and testbench

VIDEO_STREAM_WRITER -- requirements
Module: video_stream_writer

---
 rtl/video_stream_writer_pkg.sv | 14 +
 rtl/wshb_if.sv | 30 +++
 rtl/sync_fifo.sv | 55 +++++
 rtl/video_stream_writer.sv | 122 ++++++++++++
 tb/tb_video_stream_writer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_stream_writer_pkg.sv
// Shared types and constants for the video stream writer: master FSM states
// and the layout of the tagged FIFO entry.
package video_stream_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    GAP
  } state_t;

  localparam int unsigned SOF_BIT = 32;
  localparam int unsigned FIFO_W  = SOF_BIT + 1;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle with 32-bit data; modports expose only the fields
// the stream writer uses on each side.
interface wshb_if #(
  parameter int unsigned DATA_BYTES = 4
) ();

  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [31:0]               adr;
  logic [8*DATA_BYTES-1:0]   dat_ms;
  logic [8*DATA_BYTES-1:0]   dat_sm;
  logic [DATA_BYTES-1:0]     sel;
  logic [2:0]                cti;
  logic [1:0]                bte;
  logic                      ack;
  logic                      err;
  logic                      rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms,
    output ack, dat_sm, err, rty
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is refused while full and
// pop is ignored while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_din,
  output logic [WIDTH-1:0]             o_dout,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/video_stream_writer.sv
// Buffers a Wishbone pixel stream and writes it to the SDRAM frame buffer in
// bursts of up to BURST_LEN words, restarting at pixel 0 on start-of-frame.
module video_stream_writer
  import video_stream_writer_pkg::*;
#(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter logic [31:0] BASE_ADR   = '0
) (
  input  logic   sys_clk,
  input  logic   sys_rst,
  wshb_if.slave  wshb_ifs,
  wshb_if.master wshb_ifm
);

  localparam int unsigned NPIX   = HDISP * VDISP;
  localparam int unsigned PIX_W  = $clog2(NPIX);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  state_t              r_state;
  state_t              w_next;
  logic [PIX_W-1:0]    r_pix_idx;
  logic [BEAT_W-1:0]   r_beat;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [FIFO_W-1:0]   w_din;
  logic [FIFO_W-1:0]   w_head;
  logic [PIX_W-1:0]    w_eff_idx;
  logic [PIX_W-1:0]    w_eff_next;
  logic [31:0]         w_adr;

  logic                w_m_cyc;
  logic [31:0]         w_m_adr;
  logic [31:0]         w_m_dat;

  // Writes are refused while reset is held so nothing is lost into a FIFO
  // that is being cleared; reads always complete immediately.
  assign w_push = wshb_ifs.cyc & wshb_ifs.stb & wshb_ifs.we & ~w_full & ~sys_rst;
  assign w_din  = {(wshb_ifs.adr == '0), wshb_ifs.dat_ms};

  assign wshb_ifs.ack    = (wshb_ifs.cyc & wshb_ifs.stb & ~wshb_ifs.we) | w_push;
  assign wshb_ifs.dat_sm = '0;
  assign wshb_ifs.err    = 1'b0;
  assign wshb_ifs.rty    = 1'b0;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_pop      = (r_state == BURST) & wshb_ifm.ack;
  assign w_eff_idx  = w_head[SOF_BIT] ? '0 : r_pix_idx;
  assign w_eff_next = (w_eff_idx == PIX_W'(NPIX - 1)) ? '0 : w_eff_idx + PIX_W'(1);
  assign w_adr      = BASE_ADR + (32'(w_eff_idx) << 2);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= IDLE;
      r_pix_idx <= '0;
      r_beat    <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) r_pix_idx <= w_eff_next;
      if (r_state != BURST) r_beat <= '0;
      else if (w_pop)       r_beat <= r_beat + BEAT_W'(1);
    end
  end

  always_comb begin
    w_next  = r_state;
    w_m_cyc = 1'b0;
    w_m_adr = '0;
    w_m_dat = '0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_next = BURST;
      end
      BURST: begin
        w_m_cyc = 1'b1;
        w_m_adr = w_adr;
        w_m_dat = w_head[31:0];
        if (wshb_ifm.ack &&
            ((r_beat == BEAT_W'(BURST_LEN - 1)) ||
             ((w_count == CNT_W'(1)) && !w_push)))
          w_next = GAP;
      end
      GAP: begin
        // The GAP cycle is the single cyc-low cycle; pending data re-opens a
        // burst straight away so bursts are spaced by exactly one cycle.
        w_next = w_empty ? IDLE : BURST;
      end
      default: w_next = IDLE;
    endcase
  end

  assign wshb_ifm.cyc    = w_m_cyc;
  assign wshb_ifm.stb    = w_m_cyc;
  assign wshb_ifm.we     = w_m_cyc;
  assign wshb_ifm.adr    = w_m_adr;
  assign wshb_ifm.dat_ms = w_m_dat;
  assign wshb_ifm.sel    = w_m_cyc ? 4'hF : 4'h0;
  assign wshb_ifm.cti    = '0;
  assign wshb_ifm.bte    = '0;

endmodule

// File: tb/tb_video_stream_writer.sv
// Directed bench for video_stream_writer: a default-sized instance (A) and a
// tiny 4x2 frame instance (B) for the pixel-index wrap.
module tb_video_stream_writer;

  localparam logic [31:0] BASE_A = 32'h0010_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0100;

  logic        sys_clk;
  logic        sys_rst;
  logic        s_cyc;
  logic        s_we;
  logic [31:0] s_adr;
  logic [31:0] s_dat;
  logic        sel_b;
  logic        m_ack;
  logic        w_sack;

  int n_checks;
  int n_pass;
  int n_fail;
  int stall_at;
  int wr_timeout;
  int n_cap;

  logic [63:0] cap_a[$];
  logic [63:0] cap_b[$];
  int          bursts[$];
  int          gaps[$];
  int          cur_burst;
  int          gap_run;
  bit          seen_burst;
  bit          prev_cyc;
  bit          prev_stall;
  logic [31:0] prev_adr;
  logic [31:0] prev_dat;
  int          bad_ctl;
  int          unstable;

  wshb_if ifs_a ();
  wshb_if ifm_a ();
  wshb_if ifs_b ();
  wshb_if ifm_b ();

  assign ifs_a.cyc    = s_cyc & ~sel_b;
  assign ifs_a.stb    = s_cyc & ~sel_b;
  assign ifs_a.we     = s_we;
  assign ifs_a.adr    = s_adr;
  assign ifs_a.dat_ms = s_dat;
  assign ifs_a.sel    = '1;
  assign ifs_a.cti    = '0;
  assign ifs_a.bte    = '0;
  assign ifs_b.cyc    = s_cyc & sel_b;
  assign ifs_b.stb    = s_cyc & sel_b;
  assign ifs_b.we     = s_we;
  assign ifs_b.adr    = s_adr;
  assign ifs_b.dat_ms = s_dat;
  assign ifs_b.sel    = '1;
  assign ifs_b.cti    = '0;
  assign ifs_b.bte    = '0;

  assign ifm_a.ack    = m_ack & ifm_a.cyc & ifm_a.stb;
  assign ifm_a.dat_sm = '0;
  assign ifm_a.err    = 1'b0;
  assign ifm_a.rty    = 1'b0;
  assign ifm_b.ack    = m_ack & ifm_b.cyc & ifm_b.stb;
  assign ifm_b.dat_sm = '0;
  assign ifm_b.err    = 1'b0;
  assign ifm_b.rty    = 1'b0;

  assign w_sack = sel_b ? ifs_b.ack : ifs_a.ack;

  video_stream_writer #(
    .HDISP      (800),
    .VDISP      (480),
    .FIFO_DEPTH (32),
    .BURST_LEN  (16),
    .BASE_ADR   (BASE_A)
  ) dut_a (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .wshb_ifs (ifs_a),
    .wshb_ifm (ifm_a)
  );

  video_stream_writer #(
    .HDISP      (4),
    .VDISP      (2),
    .FIFO_DEPTH (32),
    .BURST_LEN  (16),
    .BASE_ADR   (BASE_B)
  ) dut_b (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .wshb_ifs (ifs_b),
    .wshb_ifm (ifm_b)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 500us");
    $fatal(1, "watchdog expired");
  end

  always @(negedge sys_clk) begin
    if (ifm_a.cyc && ifm_a.stb && ifm_a.ack) cap_a.push_back({ifm_a.adr, ifm_a.dat_ms});
    if (ifm_b.cyc && ifm_b.stb && ifm_b.ack) cap_b.push_back({ifm_b.adr, ifm_b.dat_ms});
    if (ifm_a.cyc && (ifm_a.sel !== 4'hF || ifm_a.cti !== 3'd0 || ifm_a.bte !== 2'd0 ||
                      ifm_a.we !== 1'b1 || ifm_a.stb !== 1'b1))
      bad_ctl++;
    if (prev_stall && (!ifm_a.stb || ifm_a.adr !== prev_adr || ifm_a.dat_ms !== prev_dat))
      unstable++;
    prev_stall = ifm_a.stb & ~ifm_a.ack;
    prev_adr   = ifm_a.adr;
    prev_dat   = ifm_a.dat_ms;
    if (ifm_a.cyc) begin
      if (!prev_cyc && seen_burst) gaps.push_back(gap_run);
      gap_run = 0;
      cur_burst++;
    end else begin
      if (prev_cyc) begin
        bursts.push_back(cur_burst);
        seen_burst = 1'b1;
      end
      cur_burst = 0;
      gap_run++;
    end
    prev_cyc = ifm_a.cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] qa(input int i);
    return (i < cap_a.size()) ? cap_a[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] qb(input int i);
    return (i < cap_b.size()) ? cap_b[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic clear_mon();
    cap_a.delete();
    cap_b.delete();
    bursts.delete();
    gaps.delete();
    seen_burst = 1'b0;
    cur_burst  = 0;
    gap_run    = 0;
  endtask

  // Word i goes to adr 0 (SOF) when sof_mask[i] is set, else to a nonzero adr.
  task automatic write_seq(input int n, input logic [63:0] sof_mask,
                           input logic [31:0] dbase, input int tmo);
    int acc;
    int waitc;
    acc      = 0;
    stall_at = -1;
    for (int i = 0; i < n; i++) begin
      s_cyc = 1'b1;
      s_we  = 1'b1;
      s_adr = sof_mask[i] ? 32'h0 : 32'((i + 1) * 4);
      s_dat = dbase + 32'(i);
      waitc = 0;
      @(negedge sys_clk);
      while (!w_sack && waitc < tmo) begin
        if (stall_at < 0) stall_at = acc;
        waitc++;
        @(negedge sys_clk);
      end
      if (!w_sack) begin
        wr_timeout++;
        break;
      end
      acc++;
      @(posedge sys_clk);
      #1;
    end
    s_cyc = 1'b0;
    s_we  = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0; wr_timeout = 0;
    bad_ctl = 0; unstable = 0; prev_cyc = 1'b0; prev_stall = 1'b0;
    prev_adr = '0; prev_dat = '0;
    s_cyc = 1'b0; s_we = 1'b0; s_adr = '0; s_dat = '0; sel_b = 1'b0; m_ack = 1'b1;
    sys_rst = 1'b0;
    clear_mon();

    // Reset state, with a write already requested on the slave port.
    #1 sys_rst = 1'b1;
    s_cyc = 1'b1; s_we = 1'b1; s_adr = 32'h0; s_dat = 32'h1234_5678;
    #2;
    check("rst_cyc", ifm_a.cyc, 0);
    check("rst_stb", ifm_a.stb, 0);
    check("rst_we", ifm_a.we, 0);
    check("rst_adr", ifm_a.adr, 0);
    check("rst_dat", ifm_a.dat_ms, 0);
    check("rst_sack", ifs_a.ack, 0);
    check("err_rty", {ifs_a.err, ifs_a.rty}, 0);
    #19 s_cyc = 1'b0; s_we = 1'b0;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // Slave read: same-cycle ack, zero data, nothing enqueued.
    s_cyc = 1'b1; s_we = 1'b0; s_adr = 32'h0;
    #1;
    check("rd_ack", ifs_a.ack, 1);
    check("rd_dat", ifs_a.dat_sm, 0);
    @(posedge sys_clk); #1 s_cyc = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("rd_no_push", cap_a.size(), 0);
    check("rd_no_cyc", ifm_a.cyc, 0);

    // Single SOF write.
    @(posedge sys_clk); #1 clear_mon();
    write_seq(1, 64'h1, 32'hA5A5_A5A5, 50);
    repeat (10) @(negedge sys_clk);
    check("sof_count", cap_a.size(), 1);
    check("sof_word", qa(0), {BASE_A, 32'hA5A5_A5A5});
    check("sof_bursts", bursts.size(), 1);
    check("sof_blen", (bursts.size() > 0) ? bursts[0] : -1, 1);
    check("sof_idle", ifm_a.cyc, 0);
    check("sof_nogap", gaps.size(), 0);
    check("ctl_fields", bad_ctl, 0);

    // 40 back-to-back writes with an always-ack SDRAM.
    @(posedge sys_clk); #1 clear_mon();
    write_seq(40, 64'h1, 32'hC000_0000, 50);
    for (int t = 0; t < 300 && cap_a.size() < 40; t++) @(negedge sys_clk);
    repeat (5) @(negedge sys_clk);
    check("b2b_count", cap_a.size(), 40);
    for (int i = 0; i < 40; i++)
      check("b2b_word", qa(i), {BASE_A + 32'(4 * i), 32'hC000_0000 + 32'(i)});
    check("b2b_nbursts", bursts.size(), 3);
    check("b2b_burst0", (bursts.size() > 0) ? bursts[0] : -1, 16);
    check("b2b_burst1", (bursts.size() > 1) ? bursts[1] : -1, 16);
    check("b2b_burst2", (bursts.size() > 2) ? bursts[2] : -1, 8);
    check("b2b_ngaps", gaps.size(), 2);
    check("b2b_gap0", (gaps.size() > 0) ? gaps[0] : -1, 1);
    check("b2b_gap1", (gaps.size() > 1) ? gaps[1] : -1, 1);

    // SDRAM stalled for 100 cycles while 40 writes are offered.
    @(posedge sys_clk); #1 clear_mon();
    m_ack = 1'b0;
    fork
      write_seq(40, 64'h1, 32'hD000_0000, 1000);
      begin
        repeat (100) @(posedge sys_clk);
        #1 m_ack = 1'b1;
      end
    join
    check("full_stall_at", stall_at, 32);
    for (int t = 0; t < 300 && cap_a.size() < 40; t++) @(negedge sys_clk);
    repeat (5) @(negedge sys_clk);
    check("full_count", cap_a.size(), 40);
    for (int i = 0; i < 40; i++)
      check("full_word", qa(i), {BASE_A + 32'(4 * i), 32'hD000_0000 + 32'(i)});
    check("stall_stable", unstable, 0);

    // 4x2 frame: ninth word after SOF wraps back to the base address.
    @(posedge sys_clk); #1 clear_mon();
    sel_b = 1'b1;
    write_seq(9, 64'h1, 32'hB000_0000, 50);
    for (int t = 0; t < 100 && cap_b.size() < 9; t++) @(negedge sys_clk);
    check("wrap_count", cap_b.size(), 9);
    check("wrap_w0", qb(0), {BASE_B, 32'hB000_0000});
    check("wrap_w7", qb(7), {BASE_B + 32'd28, 32'hB000_0007});
    check("wrap_w8", qb(8), {BASE_B, 32'hB000_0008});
    @(posedge sys_clk); #1 sel_b = 1'b0;

    // SOF arriving mid-frame at pixel index 5.
    @(posedge sys_clk); #1 clear_mon();
    write_seq(7, 64'h21, 32'h3800_0000, 50);
    for (int t = 0; t < 100 && cap_a.size() < 7; t++) @(negedge sys_clk);
    check("midsof_count", cap_a.size(), 7);
    check("midsof_w4", qa(4), {BASE_A + 32'd16, 32'h3800_0004});
    check("midsof_w5", qa(5), {BASE_A, 32'h3800_0005});
    check("midsof_w6", qa(6), {BASE_A + 32'd4, 32'h3800_0006});

    // Reset pulse in the middle of a burst.
    @(posedge sys_clk); #1 clear_mon();
    m_ack = 1'b0;
    write_seq(10, 64'h1, 32'hE000_0000, 50);
    @(posedge sys_clk); #1 m_ack = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk); #2;
    check("midrst_pre_cyc", ifm_a.cyc, 1);
    n_cap = cap_a.size();
    sys_rst = 1'b1;
    #1;
    check("midrst_cyc", ifm_a.cyc, 0);
    check("midrst_stb_we", {ifm_a.stb, ifm_a.we}, 0);
    check("midrst_adr", ifm_a.adr, 0);
    check("midrst_dat", ifm_a.dat_ms, 0);
    @(posedge sys_clk);
    @(posedge sys_clk); #3 sys_rst = 1'b0;
    repeat (10) @(negedge sys_clk);
    check("postrst_idle", ifm_a.cyc, 0);
    check("postrst_empty", cap_a.size(), n_cap);
    @(posedge sys_clk); #1 clear_mon();
    write_seq(1, 64'h1, 32'h5EED_0001, 50);
    for (int t = 0; t < 50 && cap_a.size() < 1; t++) @(negedge sys_clk);
    check("postrst_sof", qa(0), {BASE_A, 32'h5EED_0001});
    check("wr_timeouts", wr_timeout, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
